// File: rtl/maxmin_pkg.sv
// Shared types and helpers for the max/min parity reduction unit.
package maxmin_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/maxmin_parity_unit_popcount.sv
// Serial LSB-first popcount: bit 0 is counted on the load edge, the
// remaining WIDTH-1 bits on the following shift-enabled edges.
module serial_popcount
    import maxmin_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [WIDTH-1:0]                data,
    input  logic                            shift_en,
    output logic [clog2(WIDTH+1)-1:0]       count,
    output logic                            done
);

    localparam int PC_W = clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [PC_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]  bits_q, bits_d;

    always_comb begin
        sh_d    = sh_q;
        count_d = count_q;
        bits_d  = bits_q;
        if (load) begin
            sh_d    = data >> 1;
            count_d = PC_W'(data[0]);
            bits_d  = PC_W'(WIDTH - 1);
        end else if (shift_en && bits_q != '0) begin
            sh_d    = sh_q >> 1;
            count_d = count_q + PC_W'(sh_q[0]);
            bits_d  = bits_q - PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            count_q <= '0;
            bits_q  <= '0;
        end else begin
            sh_q    <= sh_d;
            count_q <= count_d;
            bits_q  <= bits_d;
        end
    end

    assign count = count_q;
    assign done  = (bits_q == '0);

endmodule

// File: rtl/maxmin_parity_unit.sv
// Multi-cycle max/min reduction over a burst of NUM_OPS operands with an
// even-parity flag of the winner. Define MAXMIN_FAST_PARITY_EN for XOR parity.
module maxmin_parity_unit
    import maxmin_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int NUM_OPS   = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode_min,
    input  logic                          signed_mode,
    input  logic                          op_valid,
    input  logic [WIDTH-1:0]              op_data,
    output logic                          op_ready,
    output logic                          busy,
    output logic                          result_valid,
    output logic [OUT_WIDTH-1:0]          output_result,
    output logic                          balance,
    output logic [clog2(NUM_OPS)-1:0]     win_index
);

    localparam int IDX_W = clog2(NUM_OPS);

    state_e                 state_q, state_d;
    logic                   mode_min_q, mode_min_d;
    logic                   signed_mode_q, signed_mode_d;
    logic [IDX_W-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       best_q, best_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic                   op_ready_q, op_ready_d;
    logic                   busy_q, busy_d;
    logic                   result_valid_q, result_valid_d;
    logic [OUT_WIDTH-1:0]   output_result_q, output_result_d;
    logic                   balance_q, balance_d;
    logic [IDX_W-1:0]       win_index_q, win_index_d;

`ifdef MAXMIN_FAST_PARITY_EN
    logic                   parity_q, parity_d;
`else
    localparam int PC_W = clog2(WIDTH + 1);
    logic                   pc_load;
    logic                   pc_shift;
    logic                   pc_done;
    logic [PC_W-1:0]        pc_count;

    assign pc_shift = (state_q == PARITY);

    serial_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .data     (best_d),
        .shift_en (pc_shift),
        .count    (pc_count),
        .done     (pc_done)
    );
`endif

    // Strict improvement only, so ties keep the earliest operand.
    function automatic logic improves(input logic [WIDTH-1:0] cand,
                                      input logic [WIDTH-1:0] best,
                                      input logic             min_sel,
                                      input logic             sgn);
        logic gt, lt;
        if (sgn) begin
            gt = $signed(cand) > $signed(best);
            lt = $signed(cand) < $signed(best);
        end else begin
            gt = cand > best;
            lt = cand < best;
        end
        return (min_sel == MODE_MIN) ? lt : gt;
    endfunction

    always_comb begin
        state_d         = state_q;
        mode_min_d      = mode_min_q;
        signed_mode_d   = signed_mode_q;
        count_d         = count_q;
        best_d          = best_q;
        best_idx_d      = best_idx_q;
        op_ready_d      = op_ready_q;
        busy_d          = busy_q;
        result_valid_d  = 1'b0;
        output_result_d = output_result_q;
        balance_d       = balance_q;
        win_index_d     = win_index_q;
`ifdef MAXMIN_FAST_PARITY_EN
        parity_d        = parity_q;
`else
        pc_load         = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_min_d    = mode_min;
                    signed_mode_d = signed_mode;
                    count_d       = '0;
                    op_ready_d    = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = COLLECT;
                end
            end
            COLLECT: begin
                if (op_valid && op_ready_q) begin
                    if (count_q == '0 ||
                        improves(op_data, best_q, mode_min_q, signed_mode_q)) begin
                        best_d     = op_data;
                        best_idx_d = count_q;
                    end
`ifdef MAXMIN_FAST_PARITY_EN
                    parity_d = ~^best_d;
`endif
                    count_d = count_q + IDX_W'(1);
                    if (count_q == IDX_W'(NUM_OPS - 1)) begin
                        op_ready_d = 1'b0;
`ifdef MAXMIN_FAST_PARITY_EN
                        state_d    = DONE;
`else
                        pc_load    = 1'b1;
                        state_d    = PARITY;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef MAXMIN_FAST_PARITY_EN
                state_d = DONE;
`else
                if (pc_done) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // Result registers load on the way out, so the pulse lines up with them.
                output_result_d = {OUT_WIDTH{signed_mode_q & best_q[WIDTH-1]}};
                output_result_d[WIDTH-1:0] = best_q;
`ifdef MAXMIN_FAST_PARITY_EN
                balance_d = parity_q;
`else
                balance_d = ~pc_count[0];
`endif
                win_index_d    = best_idx_q;
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mode_min_q      <= 1'b0;
            signed_mode_q   <= 1'b0;
            count_q         <= '0;
            best_q          <= '0;
            best_idx_q      <= '0;
            op_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            output_result_q <= '0;
            balance_q       <= 1'b0;
            win_index_q     <= '0;
`ifdef MAXMIN_FAST_PARITY_EN
            parity_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mode_min_q      <= mode_min_d;
            signed_mode_q   <= signed_mode_d;
            count_q         <= count_d;
            best_q          <= best_d;
            best_idx_q      <= best_idx_d;
            op_ready_q      <= op_ready_d;
            busy_q          <= busy_d;
            result_valid_q  <= result_valid_d;
            output_result_q <= output_result_d;
            balance_q       <= balance_d;
            win_index_q     <= win_index_d;
`ifdef MAXMIN_FAST_PARITY_EN
            parity_q        <= parity_d;
`endif
        end
    end

    assign op_ready      = op_ready_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign output_result = output_result_q;
    assign balance       = balance_q;
    assign win_index     = win_index_q;

endmodule
